pipe_collision_scanner: RTL and testbench
=========================================

# pipe_collision_scanner

Parametrised, sequential collision engine for the flappy-dot game: once per frame it snapshots the dot position and every pipe column's opening, scans the columns one per clock, and reports a registered hit or no-hit result with a done pulse. It sits between the column/opening generator and the game-control FSM. It replaces single-cycle, fixed-four-column checking with a configurable column count, geometry and floor, safe gap arithmetic, a sticky game-over flag and the index of the column that was hit.

## Interface
- NUM_COLS, 4: number of pipe columns (1..16)
- X_W, 8: dot x width
- Y_W, 7: dot y and opening width
- COL_BASE, 32: x of column 0
- COL_SPACING, 32: x distance between consecutive columns
- COL_THICK, 2: column thickness in pixels (x range col_x .. col_x+COL_THICK-1)
- UP_WIDTH, 11: gap extent above the opening
- DOWN_WIDTH, 34: gap extent below the opening
- FLOOR_Y, 121: floor line
- SCORE_W, 8: score counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous: abort the scan, clear sticky state and score
- start  in  1  request one scan (one-cycle pulse per frame)
- dot_x  in  X_W  dot x
- dot_y  in  Y_W  dot y
- col_op  in  NUM_COLS*Y_W  flattened openings; column i occupies [i*Y_W +: Y_W]
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse; result valid
- collided  out  1  result of the last completed scan
- hit_col  out  $clog2(NUM_COLS+1)  lowest hit column index; NUM_COLS means floor hit or no hit
- game_over  out  1  sticky; set by any collided result
- score  out  SCORE_W  columns cleared (see Configuration)

## Operation
- FSM states: IDLE, SCAN, FLOOR, DONE.
- IDLE: when start is high, snapshot dot_x, dot_y and col_op, set idx=0 and go to SCAN. busy=0.
- SCAN: evaluate column idx against the snapshot, one column per cycle. On the first hit, record hit_col=idx; later hits do not overwrite it. When idx==NUM_COLS-1, go to FLOOR.
- FLOOR: floor hit if dot_y >= FLOOR_Y. A floor hit does not change hit_col. Go to DONE.
- DONE: register collided and hit_col and pulse done. If collided, set game_over. Return to IDLE.
- Column geometry: col_x = COL_BASE + i*COL_SPACING, computed in X_W+4 bits.
- Hit condition: col_x <= x <= col_x+COL_THICK-1, and (y < top or y > bot).
  - top = op - UP_WIDTH and bot = op + DOWN_WIDTH, both signed in Y_W+2 bits.
  - Negative top means no upper hit; no wrap-around is allowed.
- start while busy is ignored; it is not queued.
- clear has priority over start. It moves the FSM to IDLE from any state, with no done pulse, and zeroes game_over, score, collided and hit_col=NUM_COLS.
- Input changes after the snapshot do not affect the result in progress.

## Timing
- Reset values: busy=0, done=0, collided=0, hit_col=NUM_COLS, game_over=0, score=0, state IDLE.
- Latency: start sampled at edge N; done is high in cycle N+NUM_COLS+2.
- busy is high from N+1 through the done cycle.
- collided and hit_col update on the same edge that raises done, and hold until the next done or clear.
- Back-to-back throughput: one scan every NUM_COLS+3 cycles, because start is accepted again in the cycle after done.
- Reset asserted mid-scan: immediate return to reset values; no done pulse.

## Configuration
- PIPE_SCORE_EN defined:
  - In DONE with no collision, score increments by 1 if snapshot x == col_x+COL_THICK for any column, meaning the dot has just cleared that column.
  - score saturates at all-ones.
- PIPE_SCORE_EN undefined: score is tied to 0 and no counter logic is built. The port list is unchanged.

## Structure
- Package pipe_collision_pkg holds:
  - the state enum (IDLE, SCAN, FLOOR, DONE)
  - default geometry constants (COL_BASE, COL_SPACING, COL_THICK, UP_WIDTH, DOWN_WIDTH, FLOOR_Y)
  - a function returning col_x for an index
- Sub-module pipe_gap_check: combinational single-column test, with inputs x, y, op and col_x and output hit. It is instantiated once and fed by the idx mux.

## Test plan
- Defaults, dot (32,5), op0=40, others 60 at non-matching x: done at N+6 with collided=1, hit_col=0, game_over=1.
- Dot (65,30), op1=25 (gap 14..59): collided=0, hit_col=4; with PIPE_SCORE_EN, x=66 gives score 0->1.
- op0=5 (top negative), dot (33,0): no upper hit and collided=0; then dot (33,40), bot=39: collided=1.
- Dot (10,121): collided=1, hit_col=4 (floor); dot (10,120): collided=0.
- start pulsed again at N+2 during a scan: ignored, exactly one done pulse.
- clear at N+3 mid-scan: no done pulse, game_over=0, FSM in IDLE.
- Score at 255 with a further clear pass: score holds at 255.

Source files
------------

// File: rtl/pipe_collision_pkg.sv
// Shared types, default geometry and column-position helper for the pipe collision scanner.
package pipe_collision_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLOOR,
        DONE
    } scan_state_t;

    localparam int unsigned DEFAULT_COL_BASE    = 32;
    localparam int unsigned DEFAULT_COL_SPACING = 32;
    localparam int unsigned DEFAULT_COL_THICK   = 2;
    localparam int unsigned DEFAULT_UP_WIDTH    = 11;
    localparam int unsigned DEFAULT_DOWN_WIDTH  = 34;
    localparam int unsigned DEFAULT_FLOOR_Y     = 121;

    function automatic int unsigned col_x_of(input int unsigned idx,
                                             input int unsigned base,
                                             input int unsigned spacing);
        return base + idx * spacing;
    endfunction

endpackage

// File: rtl/pipe_gap_check.sv
// Combinational single-column test: is the dot inside the column's x span and outside its gap?
module pipe_gap_check #(
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 7,
    parameter int unsigned COL_THICK  = 2,
    parameter int unsigned UP_WIDTH   = 11,
    parameter int unsigned DOWN_WIDTH = 34
) (
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic [Y_W-1:0]   op,
    input  logic [X_W+3:0]   col_x,
    output logic             hit
);

    localparam int unsigned CX_W = X_W + 4;
    localparam int unsigned G_W  = Y_W + 2;

    logic [CX_W-1:0]       x_ext;
    logic [CX_W-1:0]       col_end;
    logic signed [G_W-1:0] y_ext;
    logic signed [G_W-1:0] top;
    logic signed [G_W-1:0] bot;
    logic                  in_x;
    logic                  upper_hit;
    logic                  lower_hit;

    assign x_ext   = CX_W'(x);
    assign col_end = col_x + CX_W'(COL_THICK - 1);
    assign in_x    = (x_ext >= col_x) && (x_ext <= col_end);

    // Signed gap bounds: a negative top means the gap reaches the screen top.
    assign y_ext = $signed(G_W'(y));
    assign top   = $signed(G_W'(op)) - $signed(G_W'(UP_WIDTH));
    assign bot   = $signed(G_W'(op)) + $signed(G_W'(DOWN_WIDTH));

    assign upper_hit = !top[G_W-1] && (y_ext < top);
    assign lower_hit = y_ext > bot;
    assign hit       = in_x && (upper_hit || lower_hit);

endmodule

// File: rtl/pipe_collision_scanner.sv
// Per-frame sequential collision scan over NUM_COLS pipe columns plus the floor.
// Optional score counter enabled by defining PIPE_SCORE_EN.
module pipe_collision_scanner
    import pipe_collision_pkg::*;
#(
    parameter int unsigned NUM_COLS    = 4,
    parameter int unsigned X_W         = 8,
    parameter int unsigned Y_W         = 7,
    parameter int unsigned COL_BASE    = DEFAULT_COL_BASE,
    parameter int unsigned COL_SPACING = DEFAULT_COL_SPACING,
    parameter int unsigned COL_THICK   = DEFAULT_COL_THICK,
    parameter int unsigned UP_WIDTH    = DEFAULT_UP_WIDTH,
    parameter int unsigned DOWN_WIDTH  = DEFAULT_DOWN_WIDTH,
    parameter int unsigned FLOOR_Y     = DEFAULT_FLOOR_Y,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              start,
    input  logic [X_W-1:0]                    dot_x,
    input  logic [Y_W-1:0]                    dot_y,
    input  logic [NUM_COLS*Y_W-1:0]           col_op,
    output logic                              busy,
    output logic                              done,
    output logic                              collided,
    output logic [$clog2(NUM_COLS+1)-1:0]     hit_col,
    output logic                              game_over,
    output logic [SCORE_W-1:0]                score
);

    localparam int unsigned HIT_W = $clog2(NUM_COLS + 1);
    localparam int unsigned CX_W  = X_W + 4;
    localparam logic [HIT_W-1:0] NO_HIT   = HIT_W'(NUM_COLS);
    localparam logic [HIT_W-1:0] LAST_IDX = HIT_W'(NUM_COLS - 1);

    scan_state_t state;
    scan_state_t state_next;

    logic [X_W-1:0]          x_snap;
    logic [Y_W-1:0]          y_snap;
    logic [NUM_COLS*Y_W-1:0] op_snap;
    logic [HIT_W-1:0]        idx;
    logic [HIT_W-1:0]        first_hit;
    logic [Y_W-1:0]          cur_op;
    logic [CX_W-1:0]         cur_col_x;
    logic                    col_hit;
    logic                    floor_hit;
    logic                    scan_coll;

    always_comb begin
        cur_op    = '0;
        cur_col_x = '0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            if (idx == HIT_W'(i)) begin
                cur_op    = op_snap[i*Y_W +: Y_W];
                cur_col_x = CX_W'(col_x_of(i, COL_BASE, COL_SPACING));
            end
        end
    end

    pipe_gap_check #(
        .X_W        (X_W),
        .Y_W        (Y_W),
        .COL_THICK  (COL_THICK),
        .UP_WIDTH   (UP_WIDTH),
        .DOWN_WIDTH (DOWN_WIDTH)
    ) u_gap_check (
        .x     (x_snap),
        .y     (y_snap),
        .op    (cur_op),
        .col_x (cur_col_x),
        .hit   (col_hit)
    );

    assign floor_hit = 32'(y_snap) >= FLOOR_Y;
    assign scan_coll = (first_hit != NO_HIT) || floor_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (idx == LAST_IDX) state_next = FLOOR;
            FLOOR:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    // Results are loaded on the FLOOR->DONE edge so they appear together with done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_snap    <= '0;
            y_snap    <= '0;
            op_snap   <= '0;
            idx       <= '0;
            first_hit <= NO_HIT;
            collided  <= 1'b0;
            hit_col   <= NO_HIT;
            game_over <= 1'b0;
        end else if (clear) begin
            idx       <= '0;
            first_hit <= NO_HIT;
            collided  <= 1'b0;
            hit_col   <= NO_HIT;
            game_over <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_snap    <= dot_x;
                        y_snap    <= dot_y;
                        op_snap   <= col_op;
                        idx       <= '0;
                        first_hit <= NO_HIT;
                    end
                end
                SCAN: begin
                    if (col_hit && (first_hit == NO_HIT)) begin
                        first_hit <= idx;
                    end
                    idx <= idx + 1'b1;
                end
                FLOOR: begin
                    collided <= scan_coll;
                    hit_col  <= first_hit;
                    if (scan_coll) begin
                        game_over <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_SCORE_EN
    logic any_cleared;

    always_comb begin
        any_cleared = 1'b0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            if (CX_W'(x_snap) == CX_W'(col_x_of(i, COL_BASE, COL_SPACING) + COL_THICK)) begin
                any_cleared = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score <= '0;
        end else if (clear) begin
            score <= '0;
        end else if ((state == FLOOR) && !scan_coll && any_cleared && (score != '1)) begin
            score <= score + 1'b1;
        end
    end
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_pipe_collision_scanner.sv
// Randomised and directed bench for pipe_collision_scanner against a behavioural frame model.
module tb_pipe_collision_scanner;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        start;
    logic [7:0]  dot_x;
    logic [6:0]  dot_y;
    logic [27:0] col_op;
    logic        busy;
    logic        done;
    logic        collided;
    logic [2:0]  hit_col;
    logic        game_over;
    logic [7:0]  score;

    int errors = 0;
    int checks = 0;
    int m_game_over = 0;
    int m_score = 0;

    pipe_collision_scanner dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .start     (start),
        .dot_x     (dot_x),
        .dot_y     (dot_y),
        .col_op    (col_op),
        .busy      (busy),
        .done      (done),
        .collided  (collided),
        .hit_col   (hit_col),
        .game_over (game_over),
        .score     (score)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame model: columns at 32+32*i, two pixels wide, gap [op-11, op+34] clipped at 0.
    function automatic void ref_scan(input int x, input int y, input int op[4],
                                     output int coll, output int hc, output bit clr);
        hc  = NC;
        clr = 1'b0;
        for (int i = 0; i < NC; i++) begin
            int cx  = 32 + 32 * i;
            int top = op[i] - 11;
            int bot = op[i] + 34;
            if (x >= cx && x <= cx + 1 && ((top >= 0 && y < top) || y > bot) && hc == NC)
                hc = i;
            if (x == cx + 2)
                clr = 1'b1;
        end
        coll = (hc != NC || y >= 121) ? 1 : 0;
    endfunction

    task automatic set_inputs(input int x, input int y, input int op[4]);
        dot_x = 8'(x);
        dot_y = 7'(y);
        for (int i = 0; i < NC; i++)
            col_op[i*7 +: 7] = 7'(op[i]);
    endtask

    task automatic model_clear();
        m_game_over = 0;
        m_score     = 0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
    endtask

    task automatic run_scan(input string tag, input int x, input int y, input int op[4]);
        int coll, hc, n;
        bit clr;
        ref_scan(x, y, op, coll, hc, clr);
        set_inputs(x, y, op);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, "_busy"}, busy, 1);
        dot_x  = 8'($urandom);
        dot_y  = 7'($urandom);
        col_op = 28'($urandom);
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, n, NC + 2);
        if (coll != 0) m_game_over = 1;
`ifdef PIPE_SCORE_EN
        if (coll == 0 && clr && m_score < 255) m_score++;
`endif
        check_eq({tag, "_collided"}, collided, coll);
        check_eq({tag, "_hit_col"}, hit_col, hc);
        check_eq({tag, "_game_over"}, game_over, m_game_over);
        check_eq({tag, "_score"}, score, m_score);
        check_eq({tag, "_busy_done"}, busy, 1);
        tick();
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int ops[4];
        int pulses, first, n, x, y;

        reset  = 1'b1;
        clear  = 1'b0;
        start  = 1'b0;
        dot_x  = '0;
        dot_y  = '0;
        col_op = '0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_collided", collided, 0);
        check_eq("rst_hit_col", hit_col, NC);
        check_eq("rst_game_over", game_over, 0);
        check_eq("rst_score", score, 0);
        tick();

        ops = '{40, 60, 60, 60};
        run_scan("upper_hit_col0", 32, 5, ops);
        do_clear();
        check_eq("clr_game_over", game_over, 0);
        check_eq("clr_hit_col", hit_col, NC);

        ops = '{60, 25, 60, 60};
        run_scan("in_gap_col1", 65, 30, ops);
        run_scan("cleared_col1", 66, 30, ops);

        ops = '{5, 60, 60, 60};
        run_scan("neg_top", 33, 0, ops);
        run_scan("below_bot", 33, 40, ops);
        do_clear();

        ops = '{60, 60, 60, 60};
        run_scan("floor_hit", 10, 121, ops);
        run_scan("above_floor", 10, 120, ops);
        do_clear();

        // start re-pulsed mid-scan must be ignored
        set_inputs(200, 50, ops);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        first  = 0;
        for (n = 3; n < 25; n++) begin
            if (done) begin
                pulses++;
                if (first == 0) first = n;
            end
            tick();
        end
        check_eq("restart_pulses", pulses, 1);
        check_eq("restart_latency", first, NC + 2);
        check_eq("restart_collided", collided, 0);

        // clear mid-scan aborts without a done pulse
        ops = '{40, 60, 60, 60};
        run_scan("pre_abort", 32, 5, ops);
        set_inputs(32, 5, ops);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) pulses++;
            tick();
        end
        check_eq("abort_pulses", pulses, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_game_over", game_over, 0);
        check_eq("abort_collided", collided, 0);
        check_eq("abort_hit_col", hit_col, NC);
        check_eq("abort_score", score, 0);

        // asynchronous reset mid-scan
        run_scan("pre_reset", 32, 5, ops);
        set_inputs(32, 5, ops);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_collided", collided, 0);
        check_eq("arst_hit_col", hit_col, NC);
        check_eq("arst_game_over", game_over, 0);
        model_clear();
        tick();
        reset = 1'b0;
        tick();

        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 1) == 1)
                x = 32 + 32 * int'($urandom_range(0, 3)) + int'($urandom_range(0, 4)) - 1;
            else
                x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 127));
            for (int i = 0; i < NC; i++)
                ops[i] = int'($urandom_range(0, 127));
            run_scan("random", x, y, ops);
            if ($urandom_range(0, 15) == 0) do_clear();
        end

        do_clear();
        ops = '{60, 60, 60, 60};
        for (int r = 0; r < 258; r++)
            run_scan("saturate", 34, 50, ops);
`ifdef PIPE_SCORE_EN
        check_eq("score_saturated", score, 255);
`else
        check_eq("score_tied", score, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
